// File: rtl/dma_desc_sequencer_if.sv
// dma_desc_sequencer_if: AXI-Lite descriptor read channel plus data-engine command/completion handshake.
interface dma_desc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m_araddr;
    logic [2:0]        m_arprot;
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_last;
    logic              cmp_valid;
    logic              cmp_err;
    modport master (
        output m_araddr, m_arprot, m_arvalid, m_rready, cmd_valid, cmd_addr, cmd_last,
        input  m_arready, m_rdata, m_rresp, m_rvalid, cmd_ready, cmp_valid, cmp_err
    );
    modport slave (
        input  m_araddr, m_arprot, m_arvalid, m_rready, cmd_valid, cmd_addr, cmd_last,
        output m_arready, m_rdata, m_rresp, m_rvalid, cmd_ready, cmp_valid, cmp_err
    );
endinterface

// File: rtl/dma_desc_sequencer.sv
// dma_desc_sequencer: walks a descriptor chain over AXI-Lite and issues one data-engine command per descriptor.
// Define DMA_DESC_SEQ_IRQ_EN to decode the IOC bit and drive desc_irq.
module dma_desc_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int MAX_DESC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    top_desc_ptr,
    input  logic [ADDR_W-1:0]    bot_desc_ptr,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           err_code,
    output logic [7:0]           desc_count,
    output logic                 desc_irq,
    dma_desc_sequencer_if.master bus
);
    localparam int CW = $clog2(MAX_DESC + 1);
    typedef enum logic [2:0] {IDLE, AR, R, CMD, WCMP, DONE, ERR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] nxt;
    logic [1:0]        widx;
    logic [CW-1:0]     ncomp;
    logic              is_bot;
    logic              nxt_bad;
    assign is_bot        = cur == bot_desc_ptr;
    assign nxt_bad       = nxt == '0 || nxt[1:0] != 2'b00;
    assign bus.m_arprot  = 3'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cur            <= '0;
            nxt            <= '0;
            widx           <= '0;
            ncomp          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 3'd0;
            desc_count     <= 8'd0;
            bus.m_araddr   <= '0;
            bus.m_arvalid  <= 1'b0;
            bus.m_rready   <= 1'b0;
            bus.cmd_valid  <= 1'b0;
            bus.cmd_addr   <= '0;
            bus.cmd_last   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur          <= top_desc_ptr;
                    widx         <= '0;
                    ncomp        <= '0;
                    desc_count   <= 8'd0;
                    err_code     <= 3'd0;
                    bus.m_araddr <= top_desc_ptr;
                    if (top_desc_ptr[1:0] != 2'b00) begin
                        err_code <= 3'd1;
                        error    <= 1'b1;
                        state    <= ERR;
                    end else begin
                        busy          <= 1'b1;
                        bus.m_arvalid <= 1'b1;
                        state         <= AR;
                    end
                end
                AR: if (bus.m_arready) begin
                    bus.m_arvalid <= 1'b0;
                    bus.m_rready  <= 1'b1;
                    state         <= R;
                end
                R: if (bus.m_rvalid) begin
                    bus.m_rready <= 1'b0;
                    if (bus.m_rresp != 2'b00) begin
                        err_code <= 3'd2;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERR;
                    end else begin
                        widx <= widx + 2'd1;
                        if (widx == 2'd0) nxt <= ADDR_W'(bus.m_rdata);
                        if (widx == 2'd1) bus.cmd_addr <= ADDR_W'(bus.m_rdata);
                        if (widx == 2'd2) begin
                            bus.cmd_valid <= 1'b1;
                            bus.cmd_last  <= is_bot;
                            state         <= CMD;
                        end else begin
                            bus.m_araddr  <= bus.m_araddr + ADDR_W'(4);
                            bus.m_arvalid <= 1'b1;
                            state         <= AR;
                        end
                    end
                end
                CMD: if (bus.cmd_ready) begin
                    bus.cmd_valid <= 1'b0;
                    state         <= WCMP;
                end
                WCMP: if (bus.cmp_valid) begin
                    if (bus.cmp_err) begin
                        err_code <= 3'd3;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERR;
                    end else begin
                        desc_count <= desc_count + 8'(desc_count != 8'hff);
                        ncomp      <= ncomp + CW'(1);
                        if (is_bot) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else if (nxt_bad || ncomp == CW'(MAX_DESC - 1)) begin
                            err_code <= nxt_bad ? 3'd4 : 3'd5;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ERR;
                        end else begin
                            cur           <= nxt;
                            widx          <= '0;
                            bus.m_araddr  <= nxt;
                            bus.m_arvalid <= 1'b1;
                            state         <= AR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DMA_DESC_SEQ_IRQ_EN
    logic ioc;
    always_ff @(posedge clk) begin
        if (rst) begin
            ioc      <= 1'b0;
            desc_irq <= 1'b0;
        end else begin
            desc_irq <= state == WCMP && bus.cmp_valid && !bus.cmp_err && ioc;
            if (state == R && bus.m_rvalid && bus.m_rresp == 2'b00 && widx == 2'd2) ioc <= bus.m_rdata[0];
        end
    end
`else
    assign desc_irq = 1'b0;
`endif
endmodule

// File: doc/dma_desc_sequencer.md
# dma_desc_sequencer

Descriptor-chain controller for the DMA IP. On a start pulse it walks a linked list of descriptors in descriptor memory through an AXI-Lite read master. For each descriptor it issues one transfer command to the AXI-Full data engine and waits for that engine's completion. It sits between the configuration register block (top/bottom descriptor pointers, start) and the data engine, and is the only sequencer of the data path.

## Interface
Parameters:
- `ADDR_W`, 32, descriptor-pointer and buffer-address width.
- `MAX_DESC`, 256, chain-length limit; the descriptor number MAX_DESC+1 raises an error.

Ports:
- `clk` in 1: single clock; every port is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a chain; ignored while `busy`.
- `top_desc_ptr` in ADDR_W: address of the first descriptor.
- `bot_desc_ptr` in ADDR_W: address of the last descriptor.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` or `error` asserts.
- `done` out 1: one-cycle pulse when the chain completes.
- `error` out 1: one-cycle pulse when the chain aborts.
- `err_code` out 3: abort cause; holds until the next `start`.
- `desc_count` out 8: number of descriptors completed in the current or last chain; saturates at 255.
- `desc_irq` out 1: one-cycle pulse after completion of a descriptor whose IOC bit is set.
- `m_araddr` out ADDR_W, `m_arprot` out 3 (constant 0), `m_arvalid` out 1, `m_arready` in 1: AXI-Lite read-address channel.
- `m_rdata` in 32, `m_rresp` in 2, `m_rvalid` in 1, `m_rready` out 1: AXI-Lite read-data channel.
- `cmd_valid` out 1, `cmd_ready` in 1: command handshake to the data engine.
- `cmd_addr` out ADDR_W: buffer address for the command.
- `cmd_last` out 1: marks the command for the bottom descriptor.
- `cmp_valid` in 1: data engine completion pulse.
- `cmp_err` in 1: data engine error, qualified by `cmp_valid`.

## Operation
Descriptor layout, 12 bytes at pointer P:
- Word 0 at P+0: next pointer.
- Word 1 at P+4: buffer address.
- Word 2 at P+8: control. Bit 0 is IOC; all other bits are ignored.

State machine (`cur` is the current descriptor pointer, `widx` is 0..2):
- IDLE: on `start`, load `cur`=`top_desc_ptr`, `widx`=0, clear `desc_count` and `err_code`, go to AR.
  - If `top_desc_ptr`[1:0]≠0, go to ERR with code 1.
- AR: drive `m_arvalid`=1 with `m_araddr`=`cur`+4·`widx`. On `m_arready`, go to R.
- R: drive `m_rready`=1. On `m_rvalid`:
  - If `m_rresp`≠0, go to ERR with code 2.
  - Otherwise store the word and increment `widx`.
  - If `widx` was 2, go to CMD; else go to AR.
- CMD: drive `cmd_valid`=1, `cmd_addr`=word1, `cmd_last`=(`cur`==`bot_desc_ptr`). On `cmd_ready`, go to WCMP.
- WCMP: wait for `cmp_valid`.
  - If `cmp_err`, go to ERR with code 3.
  - Otherwise increment `desc_count` and pulse `desc_irq` if IOC is set.
  - If `cur`==`bot_desc_ptr`, go to DONE.
  - Else if next==0 or next[1:0]≠0, go to ERR with code 4.
  - Else if the completed-descriptor count reaches MAX_DESC, go to ERR with code 5.
  - Else set `cur`=next, `widx`=0, go to AR.
- DONE: pulse `done`, return to IDLE.
- ERR: pulse `error`, return to IDLE.

Other rules:
- Only one AXI read is outstanding at a time; `m_rready` is high only in R.
- Only one command is outstanding at a time.
- A `cmp_valid` outside WCMP is ignored.
- `start` during `busy` is ignored.
- `top_desc_ptr` and `bot_desc_ptr` are sampled live in every comparison; software must hold them stable while `busy`.
- `cur`+4·`widx` wraps modulo 2^ADDR_W.

## Timing
- Reset values: every output is 0, `err_code`=0, state IDLE.
- Reset mid-chain: `m_arvalid` and `cmd_valid` drop in the cycle after `rst` is sampled. A read response arriving later is ignored because `m_rready`=0.
- `start` sampled at edge N → `busy`=1 and `m_arvalid`=1 from N+1.
- `m_arvalid` and `m_araddr` are held stable until `m_arready`. `m_arvalid` deasserts the cycle after the handshake.
- `cmd_valid`, `cmd_addr` and `cmd_last` are held stable until `cmd_ready`.
- Minimum per-descriptor overhead, with zero-wait slaves: 3×(AR + R) = 6 cycles, plus 1 CMD cycle, plus the completion wait.
- `done` / `error` pulse 1 cycle after the deciding `cmp_valid` / `m_rvalid`. `busy` falls in the same cycle.
- `desc_irq` is registered and fires 1 cycle after the qualifying `cmp_valid`.

## Configuration
- `DMA_DESC_SEQ_IRQ_EN` defined: IOC bit is decoded and `desc_irq` behaves as described above.
- Not defined: `desc_irq` is tied to 0, control word 2 is still fetched but ignored, and the IOC register is removed.

## Test plan
- Four-descriptor chain:
  - Setup: descriptors at 0x14→0x2c→0x40→0x58; buffers 0x1000, 0x2000, 0x3000, 0x4000; IOC 0,0,1,1; top=0x14, bot=0x58; pulse `start`.
  - Required commands, in order: 0x1000, 0x2000, 0x3000, 0x4000. `cmd_last` only on 0x4000.
  - Required completion: `done` pulses once, `desc_count`=4.
  - With `DMA_DESC_SEQ_IRQ_EN`: `desc_irq` pulses after commands 3 and 4.
- Single descriptor: top=bot=0x14 → one command with `cmd_last`=1, `done` pulses, `desc_count`=1, next pointer not followed.
- Slave errors and a broken chain:
  - `m_rresp`=2 on word 1 of the second descriptor → `error` pulses, `err_code`=2, `desc_count`=1, no second command.
  - Second descriptor's next pointer=0 with bot=0x58 → `error` pulses, `err_code`=4.
- Backpressure:
  - Stimulus: `m_arready` low for 5 cycles, then `cmd_ready` low for 4 cycles.
  - Required: `m_araddr` and `cmd_addr` remain stable throughout, and exactly 3 reads and 1 command per descriptor.
- Misaligned and ignored start:
  - top=0x16 → `error` pulses with `err_code`=1 and no read is issued.
  - `start` pulsed again mid-chain → ignored, chain unaffected.
- Reset mid-chain: assert `rst` while in WCMP → all outputs 0 next cycle. A fresh `start` afterwards runs the four-descriptor chain to `done`.
